am2909_next_addr_ctrl: RTL
==========================

Name: am2909_next_addr_ctrl

Overview:
- Next-address control unit driving the control inputs of an Am2909 sequencer cascade.
- Holds the microinstruction pipeline register (sequencer opcode and branch field).
- Decodes a 16-opcode next-address instruction set into S/FE/PUP/ZERO/RE plus D-source enables.
- Owns the loop counter and a shadow stack-depth tracker; sits between control-store output and Am2909 inputs.

Parameters:
- AW, 12, address/branch/counter width (three 4-bit slices)
- DEPTH, 4, Am2909 stack depth tracked by shadow counter

Ports:
- CP  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- I_IN  in  4  next-address opcode from control store
- BR_IN  in  AW  branch/count field from control store
- CCEN_N  in  1  condition enable, low=test CC_N (registered with I_IN)
- CC_N  in  1  condition, low=true (live, not registered)
- S  out  2  Am2909 source select: 00 uPC, 01 AR, 10 STK0, 11 D
- FE  out  1  stack enable, low=active
- PUP  out  1  1=push, 0=pop
- ZERO  out  1  low forces Y=0
- RE  out  1  address-register enable, low=load
- C  out  1  uPC carry-in, constant 1
- D  out  AW  registered branch field to sequencer D inputs
- PL_N, MAP_N, VECT_N  out  1 each  D-source enables, exactly one low
- CNT  out  AW  loop counter value
- CNTZ  out  1  CNT==0

Behaviour:
- Posedge CP: I_q<=I_IN, CCEN_q<=CCEN_N, D<=BR_IN. Outputs decode combinationally from I_q, CCEN_q, CNT, live CC_N.
- PASS = CCEN_q | ~CC_N. Defaults: S=00, FE=1, PUP=1, ZERO=1, RE=1, PL_N=0, MAP_N=1, VECT_N=1.
- Opcodes (pass / fail):
  0 JZ: ZERO=0; depth<=0.
  1 CJS: S=11, FE=0, PUP=1 / S=00.
  2 JMAP: S=11, MAP_N=0, PL_N=1.
  3 CJP: S=11 / S=00.
  4 PUSH: S=00, FE=0, PUP=1; on pass CNT<=D.
  5 JSRP: S=11 / S=01; always FE=0, PUP=1.
  6 CJV: S=11, VECT_N=0, PL_N=1 / S=00.
  7 JRP: S=11 / S=01.
  8 RFCT: CNT!=0: S=10, CNT<=CNT-1; CNT==0: S=00, FE=0, PUP=0.
  9 RPCT: CNT!=0: S=11, CNT<=CNT-1; CNT==0: S=00.
  10 CRTN: S=10, FE=0, PUP=0 / S=00.
  11 CJPP: S=11, FE=0, PUP=0 / S=00.
  12 LDCT: S=00, CNT<=D, RE=0.
  13 LOOP: S=00, FE=0, PUP=0 / S=10.
  14 CONT: S=00.
  15 TWB: pass: S=00, FE=0, PUP=0. Fail with CNT!=0: S=10, CNT<=CNT-1. Fail with CNT==0: S=11, FE=0, PUP=0.
- Counter:
  - Decrement never wraps below 0 (decrement only when CNT!=0).
  - Load and decrement are never simultaneous by construction.
- Reset (async, immediate):
  - I_q=0 (JZ), so ZERO=0 and Y=0 while RST is high and for the first cycle after release.
  - CCEN_q=1, D=0, CNT=0, depth=0, all flags 0.
- RST asserted mid-instruction discards the pending counter/depth update.

Optional Feature:
- STACK_CHECK_EN defined:
  - Shadow depth counter 0..DEPTH updates on each edge with FE=0: +1 if PUP=1, -1 if PUP=0.
  - Extra outputs: FULL (depth==DEPTH), OVF (sticky: push at full, depth held), UNF (sticky: pop at 0, depth held).
  - OVF and UNF clear only on RST or JZ.
- Undefined: no depth logic; FULL, OVF, UNF ports exist and are tied to 0.

Decomposition:
- Shared package am2909_pkg: opcode localparams (JZ..TWB), S encodings (SEL_UPC, SEL_AR, SEL_STK, SEL_D), DEPTH default.
- Natural sub-module: am2909_loop_counter (AW-bit load/decrement counter with zero detect).

Test Plan:
- Reset: RST=1 with I_IN=14 -> ZERO=0, CNT=0, D=0. Release RST -> ZERO=0 for one cycle, then S=00, ZERO=1.
- CJP: I_IN=3, BR_IN=0x0A5, CCEN_N=0. After edge: CC_N=0 -> S=11, D=0x0A5; CC_N=1 -> S=00. CCEN_N=1 -> S=11 regardless of CC_N.
- LDCT then RPCT: LDCT with BR_IN=3 -> CNT=3, RE=0. Hold RPCT -> S=11 for 3 cycles (CNT 3,2,1 -> 0), then S=00 with CNTZ=1; CNT stays 0.
- CJS/CRTN: CJS pass -> FE=0, PUP=1. CRTN pass -> S=10, FE=0, PUP=0. CRTN fail -> S=00, FE=1.
- JMAP/CJV: JMAP -> MAP_N=0, PL_N=1. CJV pass -> VECT_N=0. All other opcodes -> PL_N=0, MAP_N=VECT_N=1.
- STACK_CHECK_EN: 5 consecutive PUSH -> FULL=1 after the 4th, OVF=1 after the 5th. JZ -> depth=0, OVF=0. CRTN pass at depth 0 -> UNF=1.

Source files
------------

// File: rtl/am2909_pkg.sv
// Shared opcode and source-select encodings for the Am2909 next-address controller.
package am2909_pkg;

  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_JSRP = 4'd5;
  localparam logic [3:0] OP_CJV  = 4'd6;
  localparam logic [3:0] OP_JRP  = 4'd7;
  localparam logic [3:0] OP_RFCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_CRTN = 4'd10;
  localparam logic [3:0] OP_CJPP = 4'd11;
  localparam logic [3:0] OP_LDCT = 4'd12;
  localparam logic [3:0] OP_LOOP = 4'd13;
  localparam logic [3:0] OP_CONT = 4'd14;
  localparam logic [3:0] OP_TWB  = 4'd15;

  localparam logic [1:0] SEL_UPC = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;
  localparam logic [1:0] SEL_D   = 2'b11;

  localparam int DEPTH_DEFAULT = 4;

endpackage

// File: rtl/am2909_loop_counter.sv
// AW-bit loop counter: synchronous load or saturating decrement, with zero detect.
module am2909_loop_counter #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          dec_i,
  input  logic [AW-1:0] load_val_i,
  output logic [AW-1:0] cnt_o,
  output logic          zero_o
);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  assign zero_o = (cnt_q == '0);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - AW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/am2909_next_addr_ctrl.sv
// Am2909 next-address control: pipeline register, opcode decode, loop counter.
// STACK_CHECK_EN adds a shadow stack-depth tracker driving FULL/OVF/UNF.
module am2909_next_addr_ctrl
  import am2909_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          CP,
  input  logic          RST,
  input  logic [3:0]    I_IN,
  input  logic [AW-1:0] BR_IN,
  input  logic          CCEN_N,
  input  logic          CC_N,
  output logic [1:0]    S,
  output logic          FE,
  output logic          PUP,
  output logic          ZERO,
  output logic          RE,
  output logic          C,
  output logic [AW-1:0] D,
  output logic          PL_N,
  output logic          MAP_N,
  output logic          VECT_N,
  output logic [AW-1:0] CNT,
  output logic          CNTZ,
  output logic          FULL,
  output logic          OVF,
  output logic          UNF
);

  logic [3:0]    i_q;
  logic          ccen_q;
  logic [AW-1:0] d_q;
  logic          pass;
  logic          cnt_load;
  logic          cnt_dec;

  // Reset lands on JZ so the sequencer is held at address 0 until the first fetch.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      i_q    <= OP_JZ;
      ccen_q <= 1'b1;
      d_q    <= '0;
    end else begin
      i_q    <= I_IN;
      ccen_q <= CCEN_N;
      d_q    <= BR_IN;
    end
  end

  assign D    = d_q;
  assign C    = 1'b1;
  assign pass = ccen_q | ~CC_N;

  always_comb begin
    S        = SEL_UPC;
    FE       = 1'b1;
    PUP      = 1'b1;
    ZERO     = 1'b1;
    RE       = 1'b1;
    PL_N     = 1'b0;
    MAP_N    = 1'b1;
    VECT_N   = 1'b1;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (i_q)
      OP_JZ:   ZERO = 1'b0;
      OP_CJS:  if (pass) begin S = SEL_D; FE = 1'b0; end
      OP_JMAP: begin S = SEL_D; MAP_N = 1'b0; PL_N = 1'b1; end
      OP_CJP:  if (pass) S = SEL_D;
      OP_PUSH: begin FE = 1'b0; cnt_load = pass; end
      OP_JSRP: begin S = pass ? SEL_D : SEL_AR; FE = 1'b0; end
      OP_CJV:  if (pass) begin S = SEL_D; VECT_N = 1'b0; PL_N = 1'b1; end
      OP_JRP:  S = pass ? SEL_D : SEL_AR;
      OP_RFCT: begin
        if (!CNTZ) begin S = SEL_STK; cnt_dec = 1'b1; end
        else begin FE = 1'b0; PUP = 1'b0; end
      end
      OP_RPCT: if (!CNTZ) begin S = SEL_D; cnt_dec = 1'b1; end
      OP_CRTN: if (pass) begin S = SEL_STK; FE = 1'b0; PUP = 1'b0; end
      OP_CJPP: if (pass) begin S = SEL_D; FE = 1'b0; PUP = 1'b0; end
      OP_LDCT: begin cnt_load = 1'b1; RE = 1'b0; end
      OP_LOOP: begin
        if (pass) begin FE = 1'b0; PUP = 1'b0; end
        else S = SEL_STK;
      end
      OP_CONT: S = SEL_UPC;
      OP_TWB: begin
        if (pass) begin FE = 1'b0; PUP = 1'b0; end
        else if (!CNTZ) begin S = SEL_STK; cnt_dec = 1'b1; end
        else begin S = SEL_D; FE = 1'b0; PUP = 1'b0; end
      end
      default: S = SEL_UPC;
    endcase
  end

  am2909_loop_counter #(.AW(AW)) u_loop_counter (
    .clk_i      (CP),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (d_q),
    .cnt_o      (CNT),
    .zero_o     (CNTZ)
  );

`ifdef STACK_CHECK_EN
  localparam int DW = $clog2(DEPTH + 1);

  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          full;

  assign full = (depth_q == DW'(DEPTH));

  // Overflow/underflow hold the depth so it keeps mirroring the saturated hardware stack.
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (i_q == OP_JZ) begin
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (!FE) begin
      if (PUP) begin
        if (full) ovf_d = 1'b1;
        else      depth_d = depth_q + DW'(1);
      end else begin
        if (depth_q == '0) unf_d = 1'b1;
        else               depth_d = depth_q - DW'(1);
      end
    end
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign FULL = full;
  assign OVF  = ovf_q;
  assign UNF  = unf_q;
`else
  logic unused_depth;
  assign unused_depth = (DEPTH > 0);
  assign FULL = 1'b0;
  assign OVF  = 1'b0;
  assign UNF  = 1'b0;
`endif

endmodule
